// File: rtl/weight_fifo_drain_control_pkg.sv
// Shared control definitions for the weight-path sequencers (fill and drain).
// Holds the drain FSM state encoding and a constant-foldable clog2.
package weight_fifo_drain_control_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DRAIN      = 2'd1,
        SHIFT_TAIL = 2'd2,
        LOAD       = 2'd3
    } drain_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/weight_fifo_drain_control_skew_mask_gen.sv
// Diagonal skew mask: column i is enabled while count lies in [i, i+WIDTH_HEIGHT).
// Purely combinational; shared with the activation-input skew logic.
module skew_mask_gen #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int CNT_W        = 5
) (
    input  logic [CNT_W-1:0]        count,
    input  logic                    active,
    output logic [WIDTH_HEIGHT-1:0] mask
);

    int c;

    always_comb begin
        mask = '0;
        c    = int'(count);
        for (int i = 0; i < WIDTH_HEIGHT; i++) begin
            mask[i] = active && (c >= i) && (c < i + WIDTH_HEIGHT);
        end
    end

endmodule

// File: rtl/weight_fifo_drain_control.sv
// Drains a full weight tile into the shadow registers with a one-column-per-cycle skew,
// then commits it with a single load strobe. All outputs registered.
module weight_fifo_drain_control
    import weight_fifo_drain_control_pkg::*;
#(
    parameter int WIDTH_HEIGHT = 16,
    parameter int CNT_W        = clog2(2 * WIDTH_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [WIDTH_HEIGHT-1:0] fifo_pop,
    output logic [WIDTH_HEIGHT-1:0] weight_shift,
    output logic                    weight_load,
    output logic                    busy,
    output logic                    done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * WIDTH_HEIGHT - 2);

    drain_state_t            state;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        nxt_count;
    logic                    nxt_drain;
    logic [WIDTH_HEIGHT-1:0] nxt_mask;

    // The pop mask is registered, so it is generated from the count the next cycle will hold.
    always_comb begin
        nxt_drain = 1'b0;
        nxt_count = '0;
        case (state)
            IDLE: begin
                nxt_drain = start;
            end
            DRAIN: begin
                if (count != LAST_CNT) begin
                    nxt_drain = 1'b1;
                    nxt_count = count + CNT_W'(1);
                end
            end
            default: begin
                nxt_drain = 1'b0;
            end
        endcase
    end

    skew_mask_gen #(
        .WIDTH_HEIGHT (WIDTH_HEIGHT),
        .CNT_W        (CNT_W)
    ) u_skew_mask_gen (
        .count  (nxt_count),
        .active (nxt_drain),
        .mask   (nxt_mask)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            fifo_pop     <= '0;
            weight_shift <= '0;
            weight_load  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // FIFO read latency is one cycle, so the shadow shift trails the pop by one.
            weight_shift <= fifo_pop;
            fifo_pop     <= nxt_mask;
            count        <= nxt_count;
            weight_load  <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= DRAIN;
                        busy  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (count == LAST_CNT) begin
                        state <= SHIFT_TAIL;
                    end
                end
                SHIFT_TAIL: begin
                    state       <= LOAD;
                    weight_load <= 1'b1;
                    done        <= 1'b1;
                end
                LOAD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fifo_drain_control.sv
// Bench for weight_fifo_drain_control at WIDTH_HEIGHT=16 and 4, checked every cycle
// against a timeline model plus hand-computed literal expectations.
module tb_weight_fifo_drain_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start16 = 1'b0;
    logic        start4 = 1'b0;
    logic [15:0] pop16, shift16;
    logic        load16, busy16, done16;
    logic [3:0]  pop4, shift4;
    logic        load4, busy4, done4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    weight_fifo_drain_control #(.WIDTH_HEIGHT(16)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .start        (start16),
        .fifo_pop     (pop16),
        .weight_shift (shift16),
        .weight_load  (load16),
        .busy         (busy16),
        .done         (done16)
    );

    weight_fifo_drain_control #(.WIDTH_HEIGHT(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .start        (start4),
        .fifo_pop     (pop4),
        .weight_shift (shift4),
        .weight_load  (load4),
        .busy         (busy4),
        .done         (done4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: t = cycles since start was accepted (1..2W+1), 0 when idle.
    int t16 = 0;
    int t4 = 0;
    bit armed = 1'b0;

    function automatic int adv(input int t, input logic s, input int w);
        if (t == 0) return s ? 1 : 0;
        if (t == 2 * w + 1) return 0;
        return t + 1;
    endfunction

    function automatic logic [63:0] exp_pop(input int w, input int t);
        logic [63:0] m;
        m = '0;
        if (t >= 1 && t <= 2 * w - 1) begin
            for (int i = 0; i < w; i++) begin
                m[i] = (t - 1 >= i) && (t - 1 < i + w);
            end
        end
        return m;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            t16   = 0;
            t4    = 0;
            armed = 1'b1;
        end else begin
            t16 = adv(t16, start16, 16);
            t4  = adv(t4, start4, 4);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m16_pop",   pop16,   exp_pop(16, t16));
            chk("m16_shift", shift16, exp_pop(16, t16 - 1));
            chk("m16_load",  load16,  64'(t16 == 33));
            chk("m16_done",  done16,  64'(t16 == 33));
            chk("m16_busy",  busy16,  64'(t16 != 0));
            chk("m4_pop",    pop4,    exp_pop(4, t4));
            chk("m4_shift",  shift4,  exp_pop(4, t4 - 1));
            chk("m4_load",   load4,   64'(t4 == 9));
            chk("m4_done",   done4,   64'(t4 == 9));
            chk("m4_busy",   busy4,   64'(t4 != 0));
        end
    end

    // Called on the negedge of the first drain cycle; observes one W=16 tile.
    task automatic run_tile16(input string tag, input bit poke_start);
        int bitcnt[16];
        int nbusy;
        int nload;
        int load_k;
        nbusy  = 0;
        nload  = 0;
        load_k = 0;
        for (int i = 0; i < 16; i++) bitcnt[i] = 0;
        for (int k = 1; k <= 36; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1)  chk({tag, "_pop_c0"},  pop16, 16'h0001);
            if (k == 2)  chk({tag, "_pop_c1"},  pop16, 16'h0003);
            if (k == 16) chk({tag, "_pop_c15"}, pop16, 16'hFFFF);
            if (k == 17) chk({tag, "_pop_c16"}, pop16, 16'hFFFE);
            if (k == 31) chk({tag, "_pop_c30"}, pop16, 16'h8000);
            if (k == 32) chk({tag, "_shift_tail"}, shift16, 16'h8000);
            for (int i = 0; i < 16; i++) bitcnt[i] += int'(pop16[i]);
            nbusy += int'(busy16);
            if (load16) begin
                nload++;
                load_k = k;
            end
            if (poke_start) start16 = (k == 6 || k == 33);
        end
        start16 = 1'b0;
        for (int i = 0; i < 16; i++) chk($sformatf("%s_popcnt_col%0d", tag, i), bitcnt[i], 16);
        chk({tag, "_busy_len"}, nbusy, 33);
        chk({tag, "_load_cnt"}, nload, 1);
        chk({tag, "_load_cyc"}, load_k, 33);
    endtask

    initial begin
        int ndone;
        int first_busy;
        int idle_gap;
        int d[3];
        int nload;
        int nbusy;
        logic [3:0] seq4[7];

        // Reset held with start high: nothing moves.
        reset = 1'b0;
        start16 = 1'b1;
        start4 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pop16",  pop16,  16'h0);
        chk("rst_busy16", busy16, 1'b0);
        chk("rst_load4",  load4,  1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("first_pop16", pop16, 16'h0001);
        chk("first_pop4",  pop4,  4'h1);
        start16 = 1'b0;
        start4 = 1'b0;
        repeat (40) @(negedge clk);

        // Nominal tile with starts poked at count 5 and in the LOAD cycle.
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        run_tile16("nom", 1'b1);
        repeat (3) @(negedge clk);

        // Continuous start: three tiles.
        start16 = 1'b1;
        ndone = 0;
        first_busy = -1;
        idle_gap = 0;
        for (int c = 1; c <= 120 && ndone < 3; c++) begin
            @(negedge clk);
            if (busy16 && first_busy < 0) first_busy = c;
            else if (!busy16 && first_busy >= 0) idle_gap++;
            if (done16) begin
                d[ndone] = c;
                ndone++;
            end
        end
        start16 = 1'b0;
        chk("cont_ndone", ndone, 3);
        if (ndone == 3) begin
            chk("cont_gap01", d[1] - d[0], 34);
            chk("cont_gap12", d[2] - d[1], 34);
            chk("cont_first_done", d[0] - first_busy, 32);
        end
        chk("cont_idle_cycles", idle_gap, 2);
        repeat (3) @(negedge clk);

        // Reset during drain at count 20.
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_pop_c20", pop16, 16'hFFE0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_pop",   pop16,   16'h0);
        chk("mid_rst_shift", shift16, 16'h0);
        chk("mid_rst_busy",  busy16,  1'b0);
        reset = 1'b1;
        nload = 0;
        repeat (40) begin
            @(negedge clk);
            nload += int'(load16);
        end
        chk("mid_no_load", nload, 0);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        run_tile16("post", 1'b0);

        // W=4 tile.
        seq4 = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        nbusy = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= 7) chk($sformatf("w4_pop_k%0d", k), pop4, seq4[k-1]);
            else        chk($sformatf("w4_pop_k%0d", k), pop4, 4'h0);
            if (k == 8) chk("w4_shift_tail", shift4, 4'h8);
            chk($sformatf("w4_load_k%0d", k), load4, 64'(k == 9));
            nbusy += int'(busy4);
        end
        chk("w4_busy_len", nbusy, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/weight_fifo_drain_control.md
Name: weight_fifo_drain_control

Overview:
- Sequencer directly downstream of the weight-FIFO fill stage.
- Once the weight FIFOs hold a full WIDTH_HEIGHT x WIDTH_HEIGHT tile, drains them into the systolic array's weight shadow registers with a diagonal skew: column i starts one cycle after column i-1.
- Ends with a single load strobe that commits shadow weights to the active weights.
- Reports busy/done to the top-level controller.

Parameters:
- WIDTH_HEIGHT, 16, array rows = columns = number of weight FIFOs; legal range 2..64.
- CNT_W, $clog2(2*WIDTH_HEIGHT), drain counter width (derived; do not override).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- start  input  1  request to drain one tile; sampled in IDLE only.
- fifo_pop  output  WIDTH_HEIGHT  per-column FIFO read enable; bit i pops column i.
- weight_shift  output  WIDTH_HEIGHT  per-column shadow-register shift enable; equals fifo_pop delayed one cycle (FIFO read latency 1).
- weight_load  output  1  one-cycle strobe: array copies shadow weights into active weights.
- busy  output  1  high from the cycle after start is accepted through the weight_load cycle.
- done  output  1  one-cycle pulse, coincident with weight_load.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, count=0, and all outputs 0 (fifo_pop, weight_shift, weight_load, busy, done). Reset overrides all other inputs, including mid-drain. A partially drained tile is abandoned; no further pop/shift/load is issued.
- States and transitions:
  - IDLE: outputs 0. If start==1 at a posedge, go to DRAIN with count=0.
  - DRAIN: count increments every cycle. When count==2*WIDTH_HEIGHT-2, next state is SHIFT_TAIL.
  - SHIFT_TAIL: one cycle that lets the final weight_shift (delayed pop) complete. Next state is LOAD.
  - LOAD: weight_load=1, done=1 for exactly one cycle. Next state is IDLE.
- Skew rule (registered, valid in DRAIN): fifo_pop[i] = (count >= i) && (count < i+WIDTH_HEIGHT).
  - Each column pops exactly WIDTH_HEIGHT times, on consecutive cycles.
  - Column 0 pops on counts 0..W-1; column W-1 pops on counts W-1..2W-2.
- weight_shift: register of fifo_pop (1-cycle delay); cleared by reset and zero in IDLE/LOAD.
- Timing for start seen at edge T0:
  - busy=1 and fifo_pop[0]=1 from cycle T0+1.
  - Last pop (column W-1) in cycle T0+2W-1.
  - Last shift in cycle T0+2W (SHIFT_TAIL).
  - weight_load/done in cycle T0+2W+1.
  - busy=0 from cycle T0+2W+2.
  - Total busy length is 2W+1 cycles (W=16: 33).
- start while busy (any state other than IDLE) is ignored, not queued.
- start held high continuously: a new drain begins on the edge after LOAD, i.e. one IDLE cycle exists between tiles. Back-to-back tiles are therefore spaced 2W+2 cycles apart.
- Counter never wraps: its maximum value, 2W-2, fits in CNT_W bits; count is held at 0 outside DRAIN.
- No FIFO empty check: the upstream fill stage guarantees a full tile before asserting start. Popping an empty FIFO is a system error and is not detected here.

Decomposition:
- Shared control package holds:
  - the state encoding constants (IDLE=2'd0, DRAIN=2'd1, SHIFT_TAIL=2'd2, LOAD=2'd3);
  - a shared clog2 function, also used by the fill control.
- Natural sub-module: skew_mask_gen, purely combinational. Maps count and a drain-active flag to the WIDTH_HEIGHT-bit pop mask, and is reused by the activation-input skew logic.
- FSM, counter and delay register stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 -> all outputs 0 and no state change; release reset, start=1 -> fifo_pop=16'h0001 on the next cycle.
- Nominal W=16 drain: pulse start -> fifo_pop walks 0001, 0003, 0007, ... FFFF (count 15), FFFE, ... 8000 (count 30). Each bit high exactly 16 cycles; weight_shift equals fifo_pop delayed 1; weight_load=done=1 exactly once, 33 cycles after start; busy high 33 cycles.
- Ignored start: pulse start again at count=5 and at the LOAD cycle -> no extra pops; a single done.
- Continuous start: start tied high for 3 tiles -> done pulses spaced 34 cycles apart, with exactly one idle cycle between busy windows.
- Mid-operation reset: assert reset=0 at count=20 -> next cycle all outputs 0, no weight_load ever issued; a subsequent start produces a full, correct 33-cycle sequence.
- W=4 parameterisation: pulse start -> fifo_pop sequence 1, 3, 7, F, E, C, 8; weight_load on cycle 9 after start; busy high 9 cycles.
